// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline constants for the hazard controller and its helpers.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package pipe_hazard_ctrl_pkg;

  // Architectural register address width (32 GPRs).
  localparam int PIPE_REG_AW = 5;

  // x0 is hard-wired to zero, so a load targeting it never creates a hazard.
  localparam int X0_IDX = 0;

  // Value loaded into IF/ID when it is cleared (a bubble).
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Controller state encoding, kept as plain constants for legacy tools.
  typedef logic [0:0] state_t;
  localparam state_t ST_RUN      = 1'b0;
  localparam state_t ST_MDU_WAIT = 1'b1;

endpackage

// File: rtl/pipe_hazard_ctrl_loaduse.sv
// Load-use comparator: flags an ID instruction that reads the register a load in EX writes.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the result feeds the stall logic in pipe_hazard_ctrl.
// Ports:
//   rs1_D/rs2_D, use_rs1_D/use_rs2_D : source operands of the ID instruction
//   rd_E, mem_read_E                 : destination and load flag of the EX instruction
//   load_use                         : 1 when ID must wait one cycle for the load data
module hazard_loaduse_cmp
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = PIPE_REG_AW
) (
  input  logic [REG_AW-1:0] rs1_D,
  input  logic [REG_AW-1:0] rs2_D,
  input  logic              use_rs1_D,
  input  logic              use_rs2_D,
  input  logic [REG_AW-1:0] rd_E,
  input  logic              mem_read_E,
  output logic              load_use
);

  logic rd_live;
  logic hit_rs1;
  logic hit_rs2;

  // Writes to x0 are discarded, so they can never feed a dependent instruction.
  assign rd_live = (rd_E != REG_AW'(X0_IDX));

  // Only operands the instruction actually reads count; an unused field may
  // hold garbage that happens to match rd_E.
  assign hit_rs1 = use_rs1_D && (rs1_D == rd_E);
  assign hit_rs2 = use_rs2_D && (rs2_D == rd_E);

  assign load_use = mem_read_E && rd_live && (hit_rs1 || hit_rs2);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline (PC, IF/ID, ID/EX, EX/MEM controls).
// Latency: controls are combinational from state and inputs; state moves on posedge clk.
// Backpressure: holds the front end on load-use, imem wait and MDU busy; flushes on redirect.
// Ports:
//   rs1_D, rs2_D, use_rs1_D, use_rs2_D : ID operand info for load-use detection
//   rd_E, mem_read_E                   : EX load destination
//   redirect_E                         : taken branch/jump resolved in EX
//   mdu_start_E, mdu_done              : multi-cycle MUL/DIV start and completion pulse
//   imem_ready                         : fetch data valid for the current PC
//   stall_F/D/E, flush_D/E/M           : pipeline register enables/clears
//   stall_cnt                          : saturating count of cycles with stall_F=1
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W  = 32,
  parameter int REG_AW = PIPE_REG_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] rs1_D,
  input  logic [REG_AW-1:0] rs2_D,
  input  logic              use_rs1_D,
  input  logic              use_rs2_D,
  input  logic [REG_AW-1:0] rd_E,
  input  logic              mem_read_E,
  input  logic              redirect_E,
  input  logic              mdu_start_E,
  input  logic              mdu_done,
  input  logic              imem_ready,
  output logic              stall_F,
  output logic              stall_D,
  output logic              flush_D,
  output logic              stall_E,
  output logic              flush_E,
  output logic              flush_M,
  output logic [CNT_W-1:0]  stall_cnt
);

  state_t           state_q;
  state_t           state_d;
  logic             kill_q;
  logic             kill_d;
  logic [CNT_W-1:0] cnt_q;

  logic load_use;

  // Ungated control terms; the port versions are forced low during reset.
  logic sf_c;
  logic sd_c;
  logic fd_c;
  logic se_c;
  logic fe_c;
  logic fm_c;

  hazard_loaduse_cmp #(
    .REG_AW (REG_AW)
  ) u_loaduse (
    .rs1_D      (rs1_D),
    .rs2_D      (rs2_D),
    .use_rs1_D  (use_rs1_D),
    .use_rs2_D  (use_rs2_D),
    .rd_E       (rd_E),
    .mem_read_E (mem_read_E),
    .load_use   (load_use)
  );

  always_comb begin
    sf_c    = 1'b0;
    sd_c    = 1'b0;
    fd_c    = 1'b0;
    se_c    = 1'b0;
    fe_c    = 1'b0;
    fm_c    = 1'b0;
    state_d = state_q;
    kill_d  = kill_q;

    if (state_q == ST_RUN) begin
      if (redirect_E) begin
        // Both younger instructions are wrong-path; the PC takes the target.
        fd_c = 1'b1;
        fe_c = 1'b1;
        // A fetch still in flight will return a wrong-path word later; remember
        // to drop it. If the fetch completes now, the flush above discards it.
        kill_d = !imem_ready;
      end else if (load_use) begin
        // Hold ID for one cycle and bubble EX. IF/ID must not be flushed here
        // even if fetch is waiting, since a flush would destroy the held instruction.
        sf_c = 1'b1;
        sd_c = 1'b1;
        fe_c = 1'b1;
      end else if (mdu_start_E && !mdu_done) begin
        // Freeze everything up to EX and keep MEM fed with bubbles.
        sf_c    = 1'b1;
        sd_c    = 1'b1;
        se_c    = 1'b1;
        fm_c    = 1'b1;
        state_d = ST_MDU_WAIT;
      end else if (!imem_ready) begin
        // No fetch word yet: hold PC and let a bubble into ID.
        sf_c = 1'b1;
        fd_c = 1'b1;
      end else if (kill_q) begin
        // This response belongs to the abandoned path: drop it and refetch
        // at the (already redirected) PC.
        sf_c   = 1'b1;
        fd_c   = 1'b1;
        kill_d = 1'b0;
      end
    end else begin
      // MDU owns EX: redirects, loads and fetch status are not acted on here.
      // kill_q is left untouched so a pending drop survives the wait.
      if (mdu_done) begin
        state_d = ST_RUN;
      end else begin
        sf_c = 1'b1;
        sd_c = 1'b1;
        se_c = 1'b1;
        fm_c = 1'b1;
      end
    end
  end

  assign stall_F   = rst_n & sf_c;
  assign stall_D   = rst_n & sd_c;
  assign flush_D   = rst_n & fd_c;
  assign stall_E   = rst_n & se_c;
  assign flush_E   = rst_n & fe_c;
  assign flush_M   = rst_n & fm_c;
  assign stall_cnt = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      kill_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
      // Saturate rather than wrap so long runs still read as "a lot".
      if (sf_c && !(&cnt_q)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs1_D, rs2_D, rd_E;
  logic       use_rs1_D, use_rs2_D, mem_read_E, redirect_E;
  logic       mdu_start_E, mdu_done, imem_ready;

  logic        stall_F, stall_D, flush_D, stall_E, flush_E, flush_M;
  logic [31:0] stall_cnt;
  logic        d4_sf, d4_sd, d4_fd, d4_se, d4_fe, d4_fm;
  logic [3:0]  d4_cnt;

  always #5 clk = ~clk;

  pipe_hazard_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .rs1_D(rs1_D), .rs2_D(rs2_D),
    .use_rs1_D(use_rs1_D), .use_rs2_D(use_rs2_D), .rd_E(rd_E),
    .mem_read_E(mem_read_E), .redirect_E(redirect_E),
    .mdu_start_E(mdu_start_E), .mdu_done(mdu_done), .imem_ready(imem_ready),
    .stall_F(stall_F), .stall_D(stall_D), .flush_D(flush_D),
    .stall_E(stall_E), .flush_E(flush_E), .flush_M(flush_M),
    .stall_cnt(stall_cnt)
  );

  // Narrow-counter instance on the same stimulus, used for saturation.
  pipe_hazard_ctrl #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .rs1_D(rs1_D), .rs2_D(rs2_D),
    .use_rs1_D(use_rs1_D), .use_rs2_D(use_rs2_D), .rd_E(rd_E),
    .mem_read_E(mem_read_E), .redirect_E(redirect_E),
    .mdu_start_E(mdu_start_E), .mdu_done(mdu_done), .imem_ready(imem_ready),
    .stall_F(d4_sf), .stall_D(d4_sd), .flush_D(d4_fd),
    .stall_E(d4_se), .flush_E(d4_fe), .flush_M(d4_fm),
    .stall_cnt(d4_cnt)
  );

  // Output vector order: {stall_F, stall_D, flush_D, stall_E, flush_E, flush_M}
  logic [5:0] outs;
  assign outs = {stall_F, stall_D, flush_D, stall_E, flush_E, flush_M};

  localparam logic [5:0] O_NONE = 6'b000000;
  localparam logic [5:0] O_LU   = 6'b110010;
  localparam logic [5:0] O_RED  = 6'b001010;
  localparam logic [5:0] O_IW   = 6'b101000; // imem wait / kill drop
  localparam logic [5:0] O_MDU  = 6'b110101;

  typedef struct packed {
    logic [4:0] rs1; logic u1; logic [4:0] rs2; logic u2;
    logic [4:0] rd;  logic mr; logic redir; logic ms; logic md; logic ir;
  } inp_t;

  typedef struct {
    string      name;
    inp_t       in;
    logic [5:0] exp;
  } vec_t;

  typedef struct {
    string       name;
    logic [5:0]  outs;
    logic [31:0] c32;
    logic [3:0]  c4;
  } sb_t;

  sb_t   sb_q[$];
  vec_t  tbl[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  logic [31:0] exp_c32 = 0;
  logic [3:0]  exp_c4  = 0;

  function automatic inp_t mk(logic [4:0] rs1, logic u1, logic [4:0] rs2, logic u2,
                              logic [4:0] rd, logic mr, logic redir, logic ms,
                              logic md, logic ir);
    inp_t i;
    i = '{rs1:rs1, u1:u1, rs2:rs2, u2:u2, rd:rd, mr:mr, redir:redir, ms:ms, md:md, ir:ir};
    return i;
  endfunction

  function automatic vec_t v(string n, inp_t i, logic [5:0] e);
    vec_t r;
    r.name = n; r.in = i; r.exp = e;
    return r;
  endfunction

  task automatic drive(input inp_t i);
    rs1_D = i.rs1; use_rs1_D = i.u1; rs2_D = i.rs2; use_rs2_D = i.u2;
    rd_E = i.rd; mem_read_E = i.mr; redirect_E = i.redir;
    mdu_start_E = i.ms; mdu_done = i.md; imem_ready = i.ir;
  endtask

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", n, got, exp);
    end
  endtask

  task automatic check_sb();
    sb_t e;
    if (sb_q.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL scoreboard_empty got=0 expected=1");
      return;
    end
    e = sb_q.pop_front();
    chk({e.name, ".outs"}, {26'd0, outs}, {26'd0, e.outs});
    chk({e.name, ".cnt32"}, stall_cnt, e.c32);
    chk({e.name, ".cnt4"}, {28'd0, d4_cnt}, {28'd0, e.c4});
  endtask

  // One clock cycle: drive, record expectation, sample mid-cycle, advance.
  task automatic cyc(input vec_t t);
    drive(t.in);
    sb_q.push_back('{t.name, t.exp, exp_c32, exp_c4});
    #3;
    check_sb();
    @(posedge clk); #1;
    if (t.exp[5]) begin
      exp_c32 = exp_c32 + 1;
      if (exp_c4 != 4'hF) exp_c4 = exp_c4 + 1;
    end
  endtask

  inp_t IDLE, LU5, IWAIT;

  initial begin
    IDLE  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    LU5   = mk(5, 1, 0, 0, 5, 1, 0, 0, 0, 1);
    IWAIT = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset: outputs forced low even with hazard-causing inputs present.
    rst_n = 1'b0;
    drive(mk(5, 1, 0, 0, 5, 1, 1, 1, 0, 0));
    #2;
    sb_q.push_back('{"reset", O_NONE, 32'd0, 4'd0});
    check_sb();
    drive(IDLE);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    tbl.push_back(v("idle",       IDLE, O_NONE));
    tbl.push_back(v("lu_rs1",     LU5, O_LU));
    tbl.push_back(v("lu_after",   IDLE, O_NONE));
    tbl.push_back(v("lu_x0",      mk(0, 1, 0, 0, 0, 1, 0, 0, 0, 1), O_NONE));
    tbl.push_back(v("lu_rs2",     mk(0, 0, 7, 1, 7, 1, 0, 0, 0, 1), O_LU));
    tbl.push_back(v("lu_unused",  mk(7, 0, 0, 0, 7, 1, 0, 0, 0, 1), O_NONE));
    tbl.push_back(v("lu_noload",  mk(9, 1, 0, 0, 9, 0, 0, 0, 0, 1), O_NONE));
    tbl.push_back(v("redir_lu",   mk(5, 1, 0, 0, 5, 1, 1, 0, 0, 1), O_RED));
    tbl.push_back(v("iwait1",     IWAIT, O_IW));
    tbl.push_back(v("iwait2",     IWAIT, O_IW));
    tbl.push_back(v("iwait3",     IWAIT, O_IW));
    tbl.push_back(v("iwait_lu",   mk(5, 1, 0, 0, 5, 1, 0, 0, 0, 0), O_LU));
    tbl.push_back(v("iready",     IDLE, O_NONE));
    tbl.push_back(v("redir_pend", mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0), O_RED));
    tbl.push_back(v("kill_wait",  IWAIT, O_IW));
    tbl.push_back(v("kill_drop",  IDLE, O_IW));
    tbl.push_back(v("kill_clear", IDLE, O_NONE));
    tbl.push_back(v("mdu_fast",   mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1), O_NONE));
    tbl.push_back(v("mdu_fast2",  IDLE, O_NONE));

    foreach (tbl[k]) cyc(tbl[k]);

    // MDU with a pending kill: MDU wins, kill survives the wait.
    cyc(v("mdu_mkkill", mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0), O_RED));
    cyc(v("mdu_start", mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1), O_MDU));
    for (int i = 0; i < 32; i++) begin
      inp_t w;
      w = IDLE;
      if (i == 10) w = mk(5, 1, 0, 0, 5, 1, 1, 0, 0, 1); // redirect + load-use ignored
      if (i == 20) w = IWAIT;                           // fetch status ignored
      cyc(v($sformatf("mdu_wait%0d", i), w, O_MDU));
    end
    cyc(v("mdu_done",  mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1), O_NONE));
    cyc(v("kill_kept", IDLE, O_IW));
    cyc(v("post_kill", IDLE, O_NONE));
    chk("cnt4_saturated", {28'd0, d4_cnt}, 32'd15);

    // Async reset in the middle of an MDU wait.
    cyc(v("mdu2_start", mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1), O_MDU));
    cyc(v("mdu2_wait0", IDLE, O_MDU));
    cyc(v("mdu2_wait1", IDLE, O_MDU));
    drive(mk(5, 1, 0, 0, 5, 1, 1, 1, 0, 0));
    rst_n = 1'b0;
    exp_c32 = 0;
    exp_c4  = 0;
    sb_q.push_back('{"rst_mid_mdu", O_NONE, exp_c32, exp_c4});
    #2;
    check_sb();
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc(v("rst_run",   IDLE, O_NONE));
    cyc(v("rst_lu",    LU5, O_LU));
    cyc(v("rst_after", IDLE, O_NONE));

    if (sb_q.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL scoreboard_leftover got=%0d expected=0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline. Drives the enable/clear controls of the PC register and the IF/ID, ID/EX and EX/MEM pipeline registers.
- Resolves four hazard sources: load-use hazards, EX-stage branch/jump redirects, instruction-memory wait states and multi-cycle MDU operations.
- Holds a small FSM plus a kill flag that discards wrong-path fetch responses, and keeps a stall-cycle performance counter.

Parameters:
- CNT_W, 32, width of the saturating stall-cycle counter.
- REG_AW, 5, register address width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- rs1_D  in  REG_AW  source reg 1 of instruction in ID
- rs2_D  in  REG_AW  source reg 2 of instruction in ID
- use_rs1_D  in  1  ID instruction reads rs1
- use_rs2_D  in  1  ID instruction reads rs2
- rd_E  in  REG_AW  destination reg of instruction in EX
- mem_read_E  in  1  EX instruction is a load
- redirect_E  in  1  taken branch/jump resolved in EX
- mdu_start_E  in  1  multi-cycle MUL/DIV entering EX this cycle
- mdu_done  in  1  MDU result valid (one-cycle pulse)
- imem_ready  in  1  fetch data valid for current PC
- stall_F  out  1  hold PC
- stall_D  out  1  hold IF/ID
- flush_D  out  1  clear IF/ID (NOP)
- stall_E  out  1  hold ID/EX
- flush_E  out  1  clear ID/EX
- flush_M  out  1  clear EX/MEM
- stall_cnt  out  CNT_W  cycles with stall_F=1, saturating

Behaviour:
- State: FSM {RUN, MDU_WAIT}, kill_pending flag, stall_cnt. Reset: RUN, kill_pending=0, stall_cnt=0. While rst_n=0, all control outputs are 0.
- Control outputs are combinational from state and inputs. State updates on posedge clk.
- flush_D beats stall_D inside IF/ID. The controller must therefore never assert flush_D while the D instruction is being held, except on a redirect.
- RUN, priority order (highest first):
  - redirect_E=1: flush_D=1, flush_E=1, stall_F=0. The PC mux takes the target. Load-use and imem-wait stalls are suppressed this cycle.
  - If imem_ready=0 in the same cycle, kill_pending<=1.
  - load-use: mem_read_E && rd_E!=0 && ((use_rs1_D && rs1_D==rd_E) || (use_rs2_D && rs2_D==rd_E)). Response: stall_F=1, stall_D=1, flush_E=1 for exactly one cycle. flush_D=0 even if imem_ready=0.
  - mdu_start_E=1: stall_F=1, stall_D=1, stall_E=1, flush_M=1. Next state MDU_WAIT. If mdu_done is also 1 in the same cycle, stay in RUN and do not stall.
  - imem_ready=0: stall_F=1, flush_D=1 (bubble into ID while fetch waits).
  - imem_ready=1 && kill_pending=1: flush_D=1, stall_F=1, kill_pending<=0 (the stale wrong-path word is dropped and the correct-path fetch is retried).
- MDU_WAIT:
  - stall_F=stall_D=stall_E=flush_M=1 each cycle.
  - On mdu_done=1: outputs drop to 0 that same cycle, next state RUN.
  - redirect_E and mem_read_E are ignored here (EX is occupied by the MDU op). kill_pending is retained unchanged.
  - imem_ready is ignored here. Fetch resumes in RUN.
- stall_cnt increments on every cycle with stall_F=1 and saturates at all-ones.
- Async reset mid-MDU_WAIT returns to RUN and clears kill_pending and stall_cnt immediately.

Decomposition:
- Shared pipeline package holds:
  - FSM state enum {RUN, MDU_WAIT}
  - REG_AW
  - x0 index constant
  - NOP encoding 32'h0 (the IF/ID clear value)
- One natural sub-module: hazard_loaduse_cmp, the combinational load-use comparator. The remainder stays flat.

Test Plan:
- Load-use: rd_E=5, mem_read_E=1, rs1_D=5, use_rs1_D=1 → one cycle stall_F=stall_D=flush_E=1. Next cycle all 0. With rd_E=0 → no stall.
- Redirect over load-use: redirect_E=1 with a load-use match in the same cycle → flush_D=flush_E=1, stall_F=stall_D=0.
- Imem wait: imem_ready low for 3 cycles → stall_F=flush_D=1 for 3 cycles, stall_D=0, stall_cnt +3. If load-use hits during the wait → flush_D=0, stall_D=1.
- Redirect with fetch outstanding: redirect_E=1, imem_ready=0 → kill_pending=1. The next imem_ready=1 cycle gives flush_D=1, stall_F=1, then kill_pending=0. The following ready response passes (flush_D=0).
- MDU: mdu_start_E=1, mdu_done after 33 cycles → stall_F/D/E and flush_M high for 33 cycles, 0 on the done cycle, state RUN. redirect_E pulsed mid-wait has no effect.
- Reset/saturation: assert rst_n=0 during MDU_WAIT → outputs 0, state RUN, stall_cnt=0. With CNT_W=4, 20 stall cycles → stall_cnt=15.
